// File: rtl/illm_row_serializer.sv
// illm_row_serializer: gathers one sample per lane from 8 IDCT lanes and emits them serially in lane order.
// Optional build macro ILLM_SER_CLAMP_EN saturates emitted data to [0,255].
module illm_row_serializer #(
  parameter int W = 9
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] x0_d,
  input  logic [W-1:0] x1_d,
  input  logic [W-1:0] x2_d,
  input  logic [W-1:0] x3_d,
  input  logic [W-1:0] x4_d,
  input  logic [W-1:0] x5_d,
  input  logic [W-1:0] x6_d,
  input  logic [W-1:0] x7_d,
  input  logic         x0_e,
  input  logic         x1_e,
  input  logic         x2_e,
  input  logic         x3_e,
  input  logic         x4_e,
  input  logic         x5_e,
  input  logic         x6_e,
  input  logic         x7_e,
  input  logic         x0_v,
  input  logic         x1_v,
  input  logic         x2_v,
  input  logic         x3_v,
  input  logic         x4_v,
  input  logic         x5_v,
  input  logic         x6_v,
  input  logic         x7_v,
  output logic         x0_b,
  output logic         x1_b,
  output logic         x2_b,
  output logic         x3_b,
  output logic         x4_b,
  output logic         x5_b,
  output logic         x6_b,
  output logic         x7_b,
  output logic [W-1:0] s_d,
  output logic         s_e,
  output logic         s_v,
  input  logic         s_b,
  output logic         err
);
  localparam logic [1:0] S_COLLECT = 2'd0;
  localparam logic [1:0] S_EMIT    = 2'd1;
  localparam logic [1:0] S_EOS     = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;
  logic [1:0]   r_st;
  logic [W-1:0] r_hd [8];
  logic [7:0]   r_he;
  logic [7:0]   r_f;
  logic [2:0]   r_idx;
  logic [W-1:0] r_sd;
  logic         r_se;
  logic         r_sv;
  logic         r_err;
  logic [W-1:0] w_xd [8];
  logic [7:0]   w_xe;
  logic [7:0]   w_xv;
  logic [7:0]   w_xb;
  logic [7:0]   w_acc;
  assign w_xd = '{x0_d, x1_d, x2_d, x3_d, x4_d, x5_d, x6_d, x7_d};
  assign w_xe = {x7_e, x6_e, x5_e, x4_e, x3_e, x2_e, x1_e, x0_e};
  assign w_xv = {x7_v, x6_v, x5_v, x4_v, x3_v, x2_v, x1_v, x0_v};
  assign w_xb = r_f | {8{r_st != S_COLLECT}};
  assign w_acc = w_xv & ~w_xb;
  assign {x7_b, x6_b, x5_b, x4_b, x3_b, x2_b, x1_b, x0_b} = w_xb;
  assign s_d = r_sd;
  assign s_e = r_se;
  assign s_v = r_sv;
  assign err = r_err;
  function automatic logic [W-1:0] f_cv(input logic [W-1:0] v);
`ifdef ILLM_SER_CLAMP_EN
    return v[W-1] ? '0 : (int'(v) > 255 ? W'(255) : v);
`else
    return v;
`endif
  endfunction
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_st  <= S_COLLECT;
      r_hd  <= '{default: '0};
      r_he  <= '0;
      r_f   <= '0;
      r_idx <= '0;
      r_sd  <= '0;
      r_se  <= 1'b0;
      r_sv  <= 1'b0;
      r_err <= 1'b0;
    end else begin
      case (r_st)
        S_COLLECT: begin
          for (int i = 0; i < 8; i++)
            if (w_acc[i]) begin
              r_hd[i] <= w_xd[i];
              r_he[i] <= w_xe[i];
            end
          r_f <= r_f | w_acc;
          if (&r_f) begin
            if (&r_he) begin
              r_sv <= 1'b1;
              r_se <= 1'b1;
              r_sd <= '0;
              r_st <= S_EOS;
            end else if (|r_he) begin
              r_err <= 1'b1;
              r_f   <= '0;
              r_he  <= '0;
              r_st  <= S_DONE;
            end else begin
              r_idx <= '0;
              r_sd  <= f_cv(r_hd[0]);
              r_sv  <= 1'b1;
              r_se  <= 1'b0;
              r_st  <= S_EMIT;
            end
          end
        end
        S_EMIT: begin
          if (!s_b) begin
            if (r_idx == 3'd7) begin
              r_sv  <= 1'b0;
              r_f   <= '0;
              r_he  <= '0;
              r_idx <= '0;
              r_st  <= S_COLLECT;
            end else begin
              r_idx <= r_idx + 3'd1;
              r_sd  <= f_cv(r_hd[r_idx + 3'd1]);
            end
          end
        end
        S_EOS: begin
          if (!s_b) begin
            r_sv <= 1'b0;
            r_se <= 1'b0;
            r_f  <= '0;
            r_he <= '0;
            r_st <= S_DONE;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
